// File: rtl/int_requester.sv
// int_requester: four-source, fixed-priority interrupt requester for an
// IM2-style CPU interface. Rising edges on Req are latched as pending events;
// the lowest-index pending source is handed to the CPU on INTACK as a vector
// byte and stays in service until EOI. No nesting: INT is held low while a
// source is in service.
//
// Optional feature: define INT_REQUESTER_MASK_EN to add the Mask[3:0] input.
// A masked pending bit stays pending but takes no part in INT generation or
// priority selection until its mask bit clears.
//
// Handshake: INTACK and EOI are single-cycle strobes sampled on the rising
// edge of Clk. INTACK only acts in REQUEST and EOI only acts in SERVICE;
// a strobe arriving in any other state is ignored. VectorValid is a one-cycle
// registered strobe; Vector is meaningful only while it is high.
module int_requester (
  input  logic       Clk,
  input  logic       notReset,
  input  logic [3:0] Req,
  input  logic [4:0] VectorBase,
  input  logic       INTACK,
  input  logic       EOI,
`ifdef INT_REQUESTER_MASK_EN
  input  logic [3:0] Mask,
`endif
  output logic       INT,
  output logic [7:0] Vector,
  output logic       VectorValid,
  output logic [3:0] InService,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] req_q, req_d;
  logic       arm_q, arm_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] in_service_q, in_service_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;
  logic       int_q, int_d;

  logic [3:0] mask_w;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] pick_onehot;
  logic [3:0] pending_clr;
  logic [1:0] pick_idx;

`ifdef INT_REQUESTER_MASK_EN
  assign mask_w = Mask;
`else
  assign mask_w = 4'b0000;
`endif

  // Edge detection, priority pick and next-state / next-output computation.
  // arm_q stays low for the first cycle after reset so that lines already
  // high at release are copied into req_q without counting as an edge.
  always_comb begin
    rise           = arm_q ? (Req & ~req_q) : 4'b0000;
    req_d          = Req;
    arm_d          = 1'b1;
    eligible       = pending_q & ~mask_w;
    pick_idx       = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (eligible[n]) pick_idx = n[1:0];
    end
    pick_onehot    = 4'b0001 << pick_idx;
    state_d        = state_q;
    pending_clr    = 4'b0000;
    in_service_d   = in_service_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eligible) state_d = REQUEST;
      end
      REQUEST: begin
        if (!(|eligible)) begin
          state_d = IDLE;
        end else if (INTACK) begin
          state_d        = SERVICE;
          pending_clr    = pick_onehot;
          in_service_d   = pick_onehot;
          vector_d       = {VectorBase, pick_idx, 1'b0};
          vector_valid_d = 1'b1;
        end
      end
      SERVICE: begin
        if (EOI) begin
          in_service_d = 4'b0000;
          state_d      = (|eligible) ? REQUEST : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as the acknowledge clear keeps the bit set.
    pending_d = (pending_q & ~pending_clr) | rise;
    int_d     = (state_d == REQUEST);
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      state_q        <= IDLE;
      req_q          <= 4'b0000;
      arm_q          <= 1'b0;
      pending_q      <= 4'b0000;
      in_service_q   <= 4'b0000;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      int_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      arm_q          <= arm_d;
      pending_q      <= pending_d;
      in_service_q   <= in_service_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      int_q          <= int_d;
    end
  end

  assign INT         = int_q;
  assign Vector      = vector_q;
  assign VectorValid = vector_valid_q;
  assign InService   = in_service_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_int_requester.sv
// Testbench for int_requester: directed scenarios followed by randomized
// traffic, all checked against a behavioural model and a vector scoreboard.
module tb_int_requester;

  logic       Clk;
  logic       notReset;
  logic [3:0] Req;
  logic [4:0] VectorBase;
  logic       INTACK;
  logic       EOI;
  logic [3:0] mask;
  logic       INT;
  logic [7:0] Vector;
  logic       VectorValid;
  logic [3:0] InService;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // {Vector, InService} expected at each VectorValid strobe
  logic [11:0] exp_q[$];

  int_requester dut (
    .Clk        (Clk),
    .notReset   (notReset),
    .Req        (Req),
    .VectorBase (VectorBase),
    .INTACK     (INTACK),
    .EOI        (EOI),
`ifdef INT_REQUESTER_MASK_EN
    .Mask       (mask),
`endif
    .INT        (INT),
    .Vector     (Vector),
    .VectorValid(VectorValid),
    .InService  (InService),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a set of pending sources, at most one source being
  // serviced, and the CPU-facing request line.
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic       m_prev_ok;
  int         m_serving;
  logic       m_int;
  logic       m_vv;
  logic [3:0] m_ins;
  logic [3:0] m_rises;
  logic [3:0] m_elig;
  int         m_pick;

  always @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      m_pend    = 4'b0;
      m_prev_ok = 1'b0;
      m_prev    = 4'b0;
      m_serving = -1;
      m_int     = 1'b0;
      m_vv      = 1'b0;
      m_ins     = 4'b0;
    end else begin
      m_rises   = m_prev_ok ? (Req & ~m_prev) : 4'b0;
      m_prev    = Req;
      m_prev_ok = 1'b1;
      m_elig    = m_pend & ~mask;
      m_vv      = 1'b0;
      if (m_serving >= 0) begin
        if (EOI) begin
          m_serving = -1;
          m_ins     = 4'b0;
          m_int     = (m_elig != 0);
        end
      end else if (m_int && INTACK && m_elig != 0) begin
        m_pick = -1;
        for (int n = 3; n >= 0; n--) if (m_elig[n]) m_pick = n;
        m_pend[m_pick] = 1'b0;
        m_serving = m_pick;
        m_ins     = 4'b0;
        m_ins[m_pick] = 1'b1;
        m_int     = 1'b0;
        m_vv      = 1'b1;
        exp_q.push_back({VectorBase, m_pick[1:0], 1'b0, m_ins});
      end else begin
        m_int = (m_elig != 0);
      end
      m_pend = m_pend | m_rises;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [11:0] got_exp;
  always @(posedge Clk) begin
    #1;
    if (notReset) begin
      chk("int_line", INT, m_int);
      chk("vector_valid", VectorValid, m_vv);
      chk("in_service", InService, m_ins);
      if (VectorValid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vector", 1, 0);
        end else begin
          got_exp = exp_q.pop_front();
          chk("sb_vector", Vector, got_exp[11:4]);
          chk("sb_in_service", InService, got_exp[3:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ack();
    INTACK = 1'b1; tick(1); INTACK = 1'b0;
  endtask

  task automatic eoi();
    EOI = 1'b1; tick(1); EOI = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    notReset = 1'b0; Req = 4'b0; VectorBase = 5'h0; INTACK = 1'b0; EOI = 1'b0; mask = 4'b0;
    tick(2);
    chk("rst_int", INT, 0);
    chk("rst_vv", VectorValid, 0);
    chk("rst_vector", Vector, 8'h00);
    chk("rst_ins", InService, 4'b0);
    chk("rst_state", state_dbg, 0);
    notReset = 1'b1;
    tick(2);

    // single source, latency and vector format
    Req = 4'b0001; VectorBase = 5'h10;
    tick(1); chk("t1_int_early", INT, 0);
    tick(1); chk("t1_int_high", INT, 1);
    ack();
    chk("t1_vv", VectorValid, 1);
    chk("t1_vector", Vector, 8'h80);
    chk("t1_ins", InService, 4'b0001);
    chk("t1_int_low", INT, 0);
    tick(1); chk("t1_vv_once", VectorValid, 0);
    eoi(); chk("t1_ins_clr", InService, 4'b0); chk("t1_idle_int", INT, 0);
    Req = 4'b0; tick(1);

    // simultaneous edges, priority order
    Req = 4'b1010; VectorBase = 5'h00;
    tick(2); chk("t2_int", INT, 1);
    ack(); chk("t2_vec1", Vector, 8'h02); chk("t2_ins1", InService, 4'b0010);
    tick(1);
    eoi(); chk("t2_reassert", INT, 1);
    ack(); chk("t2_vec2", Vector, 8'h06); chk("t2_ins2", InService, 4'b1000);
    eoi(); Req = 4'b0; tick(1);

    // edge during service, no nesting
    Req = 4'b0001;
    tick(2); ack();
    Req = 4'b0101;
    tick(1); chk("t3_int_low_a", INT, 0);
    tick(2); chk("t3_int_low_b", INT, 0);
    eoi(); chk("t3_int_high", INT, 1);
    ack(); chk("t3_vec", Vector, 8'h04); chk("t3_ins", InService, 4'b0100);
    eoi(); Req = 4'b0; tick(1);

    // edge coincident with acknowledge of the same source
    Req = 4'b0001;
    tick(2); chk("t4_int", INT, 1);
    Req = 4'b0000; tick(1);
    Req = 4'b0001; ack(); chk("t4_ins1", InService, 4'b0001);
    tick(1);
    eoi(); chk("t4_int_again", INT, 1);
    ack(); chk("t4_vv2", VectorValid, 1); chk("t4_ins2", InService, 4'b0001);
    eoi(); chk("t4_idle", INT, 0);
    Req = 4'b0; tick(1);

    // reset during service with all lines held high
    Req = 4'b1111;
    tick(2); ack();
    #2 notReset = 1'b0;
    #1;
    chk("t5_int", INT, 0); chk("t5_vv", VectorValid, 0); chk("t5_vector", Vector, 8'h00);
    chk("t5_ins", InService, 4'b0); chk("t5_state", state_dbg, 0);
    @(negedge Clk); notReset = 1'b1;
    tick(4); chk("t5_no_int", INT, 0);
    Req = 4'b1011; tick(1); chk("t5_low_cycle", INT, 0);
    Req = 4'b1111; tick(1); chk("t5_edge_seen", INT, 0);
    tick(1); chk("t5_int_after_toggle", INT, 1);
    ack(); chk("t5_vec", Vector, 8'h04);
    eoi(); Req = 4'b0; tick(1);

`ifdef INT_REQUESTER_MASK_EN
    // masked pending bit held back until the mask clears
    mask = 4'b0001; Req = 4'b0001;
    tick(3); chk("t6_masked", INT, 0);
    mask = 4'b0000; tick(1); chk("t6_unmasked", INT, 1);
    ack(); chk("t6_vec", Vector, 8'h00);
    eoi(); Req = 4'b0; tick(1);
`endif

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      Req        = Req ^ ($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0);
      VectorBase = 5'($urandom);
      INTACK     = ($urandom_range(0, 3) == 0);
      EOI        = ($urandom_range(0, 4) == 0);
`ifdef INT_REQUESTER_MASK_EN
      if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
`endif
      notReset   = ($urandom_range(0, 299) != 0);
      tick(1);
      notReset   = 1'b1;
    end
    INTACK = 1'b0; EOI = 1'b0;
    tick(2);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
